rat_interrupt_controller: RTL and testbench
===========================================

// Module: rat_interrupt_controller
// PURPOSE
//  Parametrised multi-source interrupt controller for the RAT MCU; replaces the single INTERRUPT pin.
//  Synchronises NUM_SRC requests, latches them per source (edge or level), masks and priority-encodes them.
//  Drives one request to the control unit and a per-source ISR vector for the PC load mux.
//  Mask, pending and EOI registers are reached over the existing IN/OUT port bus (PORT_ID/IO_STRB).
// PARAMETERS
//  NUM_SRC     8        number of sources, 1..8; index 0 has the highest priority
//  EDGE_MODE   8'hFF    per-source mode: 1 = rising-edge latched, 0 = level
//  VEC_BASE    10'h3F0  vector for source 0; source k uses VEC_BASE+k
//  MASK_ID     8'hE0    PORT_ID of the mask register (R/W)
//  PEND_ID     8'hE1    PORT_ID of pending status (read) / software set (write, OR-in)
//  EOI_ID      8'hE2    PORT_ID of end-of-interrupt (write, data ignored)
// PORTS
//  CLK        in   1        system clock
//  RESET_N    in   1        synchronous reset, active low
//  IRQ_IN     in   NUM_SRC  asynchronous interrupt sources
//  I_EN       in   1        global interrupt enable (I flag from CU)
//  INT_ACK    in   1        one-cycle pulse from the CU when it enters the interrupt cycle
//  IO_STRB    in   1        output-port write strobe
//  PORT_ID    in   8        port address
//  OUT_PORT   in   8        write data from the MCU
//  INT_REQ    out  1        interrupt request to the CU
//  VEC_ADDR   out  10       ISR address for the PC mux, valid while INT_REQ=1 and in SERVICE
//  IN_DATA    out  8        read data; valid combinationally when PORT_ID is MASK_ID or PEND_ID
//  IN_SEL     out  1        1 when PORT_ID is MASK_ID or PEND_ID (steers the IN_PORT mux)
//  ACTIVE_IDX out  3        index of the source being requested or serviced
// BEHAVIOUR
//  Reset (RESET_N=0 at a rising edge) clears all state regardless of state:
//   sync flops=0, pending=0, mask=0 (all disabled), FSM=IDLE.
//   Outputs: INT_REQ=0, VEC_ADDR=VEC_BASE, ACTIVE_IDX=0.
//  Synchroniser: 2-flop chain per source, plus a third "previous" flop for edge detection.
//  Pending set:
//   - edge-mode source: set on sync=1 and prev=0.
//   - level-mode source: pending bit follows the synced level each cycle; it is not cleared by ACK.
//   - a software write to PEND_ID ORs OUT_PORT[NUM_SRC-1:0] into pending (edge-mode bits only).
//  Pending clear: edge-mode bit [ACTIVE_IDX] clears on INT_ACK. If a set and a clear hit the same bit in one cycle, set wins.
//  Eligible = pending & mask. The winner is the lowest eligible index, chosen by a fixed-priority encoder.
//  FSM:
//   IDLE:    if I_EN and eligible!=0, latch winner into ACTIVE_IDX and go to REQ.
//   REQ:     INT_REQ=1, VEC_ADDR=VEC_BASE+ACTIVE_IDX. On INT_ACK go to SERVICE.
//            If I_EN drops, or the winner's eligibility drops, before ACK: go to IDLE, no ACK needed.
//   SERVICE: INT_REQ=0. A write to EOI_ID (IO_STRB=1 and PORT_ID=EOI_ID) returns to IDLE.
//            No nesting: new requests stay pending until EOI.
//  INT_REQ and ACTIVE_IDX are registered (FSM outputs).
//  Latency: IRQ_IN rising, sampled at edge 1 -> INT_REQ high after edge 4 (2 sync, 1 pending, 1 FSM).
//  INT_ACK outside REQ is ignored. EOI outside SERVICE is ignored.
//  Register writes take effect at the next edge; a mask write clearing ACTIVE_IDX while in REQ drops to IDLE.
//  Reads: IN_DATA = mask (zero-extended) or pending (zero-extended); IN_DATA=8'h00 otherwise.
//  Bits >= NUM_SRC of the mask, pending and software-set paths are ignored and read back as 0.
//  VEC_ADDR arithmetic is 10-bit and wraps modulo 1024.
// TESTING
//  1. Reset, write mask 8'h04, pulse IRQ_IN[2] with I_EN=1
//     -> INT_REQ=1 on the 4th edge, VEC_ADDR=10'h3F2, ACTIVE_IDX=2.
//  2. Set pending 3 and 5 together, mask 8'hFF
//     -> source 3 served first (VEC 3F3); after ACK+EOI, source 5 (VEC 3F5).
//  3. While in REQ for source 1, drive I_EN=0 -> INT_REQ=0 next edge, pending[1] still 1.
//     Restore I_EN=1 -> request again.
//  4. New edge on source 0 in the same cycle as INT_ACK for source 0 -> pending[0] stays 1, re-requested after EOI.
//  5. Level source (EDGE_MODE bit 6=0) held high through ACK+EOI -> re-requested.
//     Deassert it -> pending read on PEND_ID shows bit 6=0.
//  6. Assert RESET_N=0 while in SERVICE -> INT_REQ=0, pending=0, mask reads 8'h00, FSM=IDLE.

Source files
------------

// File: rtl/rat_interrupt_controller.sv
// Multi-source interrupt controller: sync, per-source edge/level latch, mask, fixed-priority request, vector out.
// Latency: IRQ edge -> INT_REQ in 4 clocks; backpressure: none, requests wait in pending until ACK/EOI.
module rat_interrupt_controller #(
    parameter int         NUM_SRC   = 8,
    parameter logic [7:0] EDGE_MODE = 8'hFF,
    parameter logic [9:0] VEC_BASE  = 10'h3F0,
    parameter logic [7:0] MASK_ID   = 8'hE0,
    parameter logic [7:0] PEND_ID   = 8'hE1,
    parameter logic [7:0] EOI_ID    = 8'hE2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NUM_SRC-1:0] i_irq_in,
    input  logic               i_i_en,
    input  logic               i_int_ack,
    input  logic               i_io_strb,
    input  logic [7:0]         i_port_id,
    input  logic [7:0]         i_out_port,
    output logic               o_int_req,
    output logic [9:0]         o_vec_addr,
    output logic [7:0]         o_in_data,
    output logic               o_in_sel,
    output logic [2:0]         o_active_idx
);
    localparam logic [NUM_SRC-1:0] EDGE_L = EDGE_MODE[NUM_SRC-1:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic               r_int_req;
    logic [9:0]         r_vec_addr;
    logic [2:0]         r_active_idx;

    logic               w_mask_wr;
    logic               w_pend_wr;
    logic               w_eoi_wr;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_sw_set;
    logic [NUM_SRC-1:0] w_act_onehot;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [NUM_SRC-1:0] w_elig;
    logic [2:0]         w_winner;
    logic               w_any_elig;
    logic               w_act_elig;

    assign w_mask_wr  = i_io_strb && (i_port_id == MASK_ID);
    assign w_pend_wr  = i_io_strb && (i_port_id == PEND_ID);
    assign w_eoi_wr   = i_io_strb && (i_port_id == EOI_ID);
    assign w_rise     = r_sync2 & ~r_prev;
    assign w_sw_set   = w_pend_wr ? (i_out_port[NUM_SRC-1:0] & EDGE_L) : '0;
    assign w_elig     = r_pending & r_mask;
    assign w_any_elig = |w_elig;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        w_winner     = 3'd0;
        w_act_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) w_winner = 3'(i);
            w_act_onehot[i] = (r_active_idx == 3'(i));
        end
    end

    assign w_act_elig = |(w_elig & w_act_onehot);
    assign w_clr      = (r_state == ST_REQ && i_int_ack) ? w_act_onehot : '0;
    // Set terms are ORed after the clear, so a same-cycle set beats the ACK clear.
    assign w_pend_nxt = (EDGE_L & ((r_pending & ~w_clr) | w_rise | w_sw_set)) | (~EDGE_L & r_sync2);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_sync1   <= i_irq_in;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_pending <= w_pend_nxt;
            if (w_mask_wr) r_mask <= i_out_port[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_int_req    <= 1'b0;
            r_active_idx <= 3'd0;
            r_vec_addr   <= VEC_BASE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_i_en && w_any_elig) begin
                        r_state      <= ST_REQ;
                        r_int_req    <= 1'b1;
                        r_active_idx <= w_winner;
                        r_vec_addr   <= VEC_BASE + {7'd0, w_winner};
                    end
                end
                ST_REQ: begin
                    if (i_int_ack) begin
                        r_state   <= ST_SERVICE;
                        r_int_req <= 1'b0;
                    end else if (!i_i_en || !w_act_elig) begin
                        r_state   <= ST_IDLE;
                        r_int_req <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    r_int_req <= 1'b0;
                    if (w_eoi_wr) r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_in_sel  = 1'b0;
        o_in_data = 8'h00;
        if (i_port_id == MASK_ID) begin
            o_in_sel  = 1'b1;
            o_in_data = 8'(r_mask);
        end else if (i_port_id == PEND_ID) begin
            o_in_sel  = 1'b1;
            o_in_data = 8'(r_pending);
        end
    end

    assign o_int_req    = r_int_req;
    assign o_vec_addr   = r_vec_addr;
    assign o_active_idx = r_active_idx;
endmodule

// File: tb/tb_rat_interrupt_controller.sv
// Directed bench for rat_interrupt_controller; source 6 is level mode, all others edge mode.
module tb_rat_interrupt_controller;
    localparam logic [7:0] MASK_ID = 8'hE0;
    localparam logic [7:0] PEND_ID = 8'hE1;
    localparam logic [7:0] EOI_ID  = 8'hE2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic       i_en = 1'b0;
    logic       int_ack = 1'b0;
    logic       io_strb = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       int_req;
    logic [9:0] vec_addr;
    logic [7:0] in_data;
    logic       in_sel;
    logic [2:0] active_idx;

    int n_checks = 0;
    int n_fail   = 0;

    rat_interrupt_controller #(
        .NUM_SRC  (8),
        .EDGE_MODE(8'hBF),
        .VEC_BASE (10'h3F0),
        .MASK_ID  (MASK_ID),
        .PEND_ID  (PEND_ID),
        .EOI_ID   (EOI_ID)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_irq_in    (irq_in),
        .i_i_en      (i_en),
        .i_int_ack   (int_ack),
        .i_io_strb   (io_strb),
        .i_port_id   (port_id),
        .i_out_port  (out_port),
        .o_int_req   (int_req),
        .o_vec_addr  (vec_addr),
        .o_in_data   (in_data),
        .o_in_sel    (in_sel),
        .o_active_idx(active_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] port;
        logic       strb;
        logic [7:0] dat;
        logic       exp_sel;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] dat);
        port_id  = port;
        out_port = dat;
        io_strb  = 1'b1;
        tick();
        io_strb  = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] port, input logic [7:0] exp);
        port_id = port;
        #1;
        check(name, in_data, exp);
        port_id = 8'h00;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic req_chk(input string name, input logic exp_req, input logic [2:0] exp_idx);
        check({name, " req"}, int_req, exp_req);
        if (exp_req) begin
            check({name, " idx"}, active_idx, exp_idx);
            check({name, " vec"}, vec_addr, 10'h3F0 + {7'd0, exp_idx});
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        irq_in  = 8'h00;
        i_en    = 1'b0;
        int_ack = 1'b0;
        io_strb = 1'b0;
        port_id = 8'h00;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{MASK_ID, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[1]  = '{PEND_ID, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[2]  = '{EOI_ID,  1'b0, 8'h00, 1'b0, 8'h00};
        tbl[3]  = '{8'h10,   1'b0, 8'h00, 1'b0, 8'h00};
        tbl[4]  = '{MASK_ID, 1'b1, 8'hA5, 1'b1, 8'h00};
        tbl[5]  = '{MASK_ID, 1'b0, 8'h00, 1'b1, 8'hA5};
        tbl[6]  = '{PEND_ID, 1'b1, 8'hC3, 1'b1, 8'h00};
        tbl[7]  = '{PEND_ID, 1'b0, 8'h00, 1'b1, 8'h83};
        tbl[8]  = '{PEND_ID, 1'b1, 8'h40, 1'b1, 8'h83};
        tbl[9]  = '{PEND_ID, 1'b0, 8'h00, 1'b1, 8'h83};
        tbl[10] = '{EOI_ID,  1'b1, 8'h00, 1'b0, 8'h00};
        tbl[11] = '{MASK_ID, 1'b1, 8'h00, 1'b1, 8'hA5};
        tbl[12] = '{MASK_ID, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[13] = '{8'h10,   1'b1, 8'hFF, 1'b0, 8'h00};
        tbl[14] = '{MASK_ID, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[15] = '{PEND_ID, 1'b0, 8'h00, 1'b1, 8'h83};

        // Reset state
        do_reset();
        check("rst int_req", int_req, 1'b0);
        check("rst vec", vec_addr, 10'h3F0);
        check("rst idx", active_idx, 3'd0);
        rd_chk("rst mask", MASK_ID, 8'h00);
        rd_chk("rst pend", PEND_ID, 8'h00);

        // Register file vectors, interrupts globally disabled
        for (int i = 0; i < 16; i++) begin
            port_id  = tbl[i].port;
            out_port = tbl[i].dat;
            io_strb  = tbl[i].strb;
            #1;
            check($sformatf("tbl[%0d] sel", i), in_sel, tbl[i].exp_sel);
            check($sformatf("tbl[%0d] data", i), in_data, tbl[i].exp_dat);
            tick();
            io_strb = 1'b0;
        end
        tick();
        check("no req with i_en=0", int_req, 1'b0);

        // 1: latency from IRQ edge to request
        do_reset();
        wr(MASK_ID, 8'h04);
        i_en = 1'b1;
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        tick();
        tick();
        check("t1 edge3 req", int_req, 1'b0);
        tick();
        req_chk("t1 edge4", 1'b1, 3'd2);
        ack();
        check("t1 service req", int_req, 1'b0);
        rd_chk("t1 pend cleared", PEND_ID, 8'h00);
        wr(EOI_ID, 8'h00);
        tick();
        check("t1 idle after eoi", int_req, 1'b0);

        // 2: priority between two pending sources
        do_reset();
        wr(MASK_ID, 8'hFF);
        i_en = 1'b1;
        wr(PEND_ID, 8'h28);
        tick();
        req_chk("t2 first", 1'b1, 3'd3);
        ack();
        check("t2 service", int_req, 1'b0);
        tick();
        check("t2 no nesting", int_req, 1'b0);
        wr(EOI_ID, 8'h00);
        tick();
        req_chk("t2 second", 1'b1, 3'd5);
        rd_chk("t2 pend", PEND_ID, 8'h20);

        // 3: enable drop, mask drop, stray ACK
        do_reset();
        wr(MASK_ID, 8'hFF);
        i_en = 1'b1;
        wr(PEND_ID, 8'h02);
        tick();
        req_chk("t3 req", 1'b1, 3'd1);
        i_en = 1'b0;
        tick();
        check("t3 i_en drop", int_req, 1'b0);
        rd_chk("t3 pend kept", PEND_ID, 8'h02);
        i_en = 1'b1;
        tick();
        req_chk("t3 re-req", 1'b1, 3'd1);
        wr(MASK_ID, 8'h00);
        check("t3 mask wr edge", int_req, 1'b1);
        tick();
        check("t3 mask drop", int_req, 1'b0);
        ack();
        rd_chk("t3 stray ack", PEND_ID, 8'h02);

        // 4: new edge coincides with ACK of the same source
        do_reset();
        wr(MASK_ID, 8'h01);
        i_en = 1'b1;
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        tick();
        tick();
        tick();
        req_chk("t4 req", 1'b1, 3'd0);
        irq_in[0] = 1'b1;
        tick();
        tick();
        check("t4 held", int_req, 1'b1);
        ack();
        check("t4 service", int_req, 1'b0);
        rd_chk("t4 set wins", PEND_ID, 8'h01);
        wr(EOI_ID, 8'h00);
        tick();
        req_chk("t4 re-req", 1'b1, 3'd0);
        ack();
        rd_chk("t4 ack clears", PEND_ID, 8'h00);

        // 5: level-mode source 6
        do_reset();
        wr(MASK_ID, 8'h40);
        i_en = 1'b1;
        irq_in[6] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        req_chk("t5 req", 1'b1, 3'd6);
        ack();
        rd_chk("t5 level kept", PEND_ID, 8'h40);
        wr(EOI_ID, 8'h00);
        tick();
        req_chk("t5 re-req", 1'b1, 3'd6);
        irq_in[6] = 1'b0;
        tick();
        tick();
        tick();
        rd_chk("t5 level gone", PEND_ID, 8'h00);
        check("t5 req still", int_req, 1'b1);
        tick();
        check("t5 req drop", int_req, 1'b0);

        // 6: reset while in SERVICE
        do_reset();
        wr(MASK_ID, 8'hFF);
        i_en = 1'b1;
        wr(PEND_ID, 8'h10);
        tick();
        req_chk("t6 req", 1'b1, 3'd4);
        ack();
        wr(PEND_ID, 8'h01);
        check("t6 service", int_req, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6 rst req", int_req, 1'b0);
        check("t6 rst idx", active_idx, 3'd0);
        check("t6 rst vec", vec_addr, 10'h3F0);
        rd_chk("t6 rst mask", MASK_ID, 8'h00);
        rd_chk("t6 rst pend", PEND_ID, 8'h00);
        tick();
        check("t6 quiet", int_req, 1'b0);
        wr(MASK_ID, 8'hFF);
        wr(PEND_ID, 8'h04);
        tick();
        req_chk("t6 idle again", 1'b1, 3'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
